// File: rtl/pwm_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_sched_pkg                                                   |
// | Brief    : Shared FSM encodings and id-width helper for pwm_duty_scheduler |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pwm_sched_pkg;

    typedef logic [1:0] pwm_sched_state_t;

    localparam pwm_sched_state_t c_st_idle  = 2'd0;
    localparam pwm_sched_state_t c_st_issue = 2'd1;
    localparam pwm_sched_state_t c_st_ack   = 2'd2;

    // Never returns 0 so a single-requester build still has a legal index port.
    function automatic int unsigned pwm_sched_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_rr_arbiter                                                  |
// | Brief    : Combinational round-robin pick, search starts at pointer rr     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pwm_rr_arbiter
    import pwm_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                     req,
    input  logic [pwm_sched_id_width(N)-1:0] rr,
    output logic                             valid,
    output logic [pwm_sched_id_width(N)-1:0] winner
);

    localparam int c_idw = pwm_sched_id_width(N);

    logic [c_idw-1:0] w_idx;

    // Scan farthest-first so the candidate nearest to rr overwrites the others.
    always_comb begin
        valid  = |req;
        winner = '0;
        w_idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = c_idw'((int'(rr) + k) % N);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_duty_scheduler                                              |
// | Brief    : Round-robin sharing of one PWM duty-update port among N agents; |
// |            optional slew limiting under macro PWM_SCHED_RAMP_EN            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pwm_duty_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int R        = 8,
    parameter int N        = 4,
    parameter int MAX_STEP = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N-1:0]                     req,
    input  logic [N*R-1:0]                   req_duty,
    output logic [N-1:0]                     ack,
    output logic                             busy,
    output logic [pwm_sched_id_width(N)-1:0] grant_id,
    output logic [R-1:0]                     pwm_duty,
    output logic                             pwm_ready,
    input  logic                             pwm_done,
    output logic [R-1:0]                     cur_duty
);

    localparam int c_idw = pwm_sched_id_width(N);

    pwm_sched_state_t r_state;
    pwm_sched_state_t w_state_next;

    logic [c_idw-1:0] r_rr;
    logic [c_idw-1:0] r_grant_id;
    logic [R-1:0]     r_target;
    logic [R-1:0]     r_cur_duty;
    logic [R-1:0]     r_pwm_duty;
    logic             r_pwm_ready;

    logic             w_valid;
    logic [c_idw-1:0] w_winner;
    logic [R-1:0]     w_win_duty;
    logic [R-1:0]     w_grant_step;
    logic [R-1:0]     w_next_step;
    logic             w_done_take;
    logic             w_reached;
    logic             w_busy;
    logic [N-1:0]     w_ack;

    pwm_rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .req    (req),
        .rr     (r_rr),
        .valid  (w_valid),
        .winner (w_winner)
    );

    assign w_win_duty  = req_duty[int'(w_winner) * R +: R];
    // A done pulse only counts while a handshake is actually outstanding.
    assign w_done_take = (r_state == c_st_issue) && r_pwm_ready && pwm_done;
    assign w_reached   = (r_pwm_duty == r_target);

`ifdef PWM_SCHED_RAMP_EN
    localparam logic signed [R:0] c_step_s = (R + 1)'(MAX_STEP);
    localparam logic [R-1:0]      c_step   = R'(MAX_STEP);

    // Steps only when the gap exceeds MAX_STEP, so the result can never wrap.
    function automatic logic [R-1:0] f_ramp_step(input logic [R-1:0] tgt,
                                                 input logic [R-1:0] base);
        logic signed [R:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, base});
        if (diff > c_step_s) begin
            f_ramp_step = base + c_step;
        end else if (diff < -c_step_s) begin
            f_ramp_step = base - c_step;
        end else begin
            f_ramp_step = tgt;
        end
    endfunction

    assign w_grant_step = f_ramp_step(w_win_duty, r_cur_duty);
    // r_pwm_duty is the value about to become cur_duty on this done pulse.
    assign w_next_step  = f_ramp_step(r_target, r_pwm_duty);
`else
    localparam int c_unused_max_step = MAX_STEP;

    assign w_grant_step = w_win_duty;
    assign w_next_step  = r_target;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_valid) begin
                    w_state_next = c_st_issue;
                end
            end
            c_st_issue: begin
                if (w_done_take && w_reached) begin
                    w_state_next = c_st_ack;
                end
            end
            c_st_ack: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_busy = (r_state != c_st_idle);
        w_ack  = '0;
        if (r_state == c_st_ack) begin
            w_ack[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr        <= '0;
            r_grant_id  <= '0;
            r_target    <= '0;
            r_cur_duty  <= '0;
            r_pwm_duty  <= '0;
            r_pwm_ready <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_valid) begin
                        r_grant_id  <= w_winner;
                        r_rr        <= (w_winner == c_idw'(N - 1)) ? '0 : w_winner + 1'b1;
                        r_target    <= w_win_duty;
                        r_pwm_duty  <= w_grant_step;
                        r_pwm_ready <= 1'b1;
                    end
                end
                c_st_issue: begin
                    if (w_done_take) begin
                        r_cur_duty  <= r_pwm_duty;
                        r_pwm_ready <= 1'b0;
                        if (!w_reached) begin
                            r_pwm_duty <= w_next_step;
                        end
                    end else if (!r_pwm_ready) begin
                        // Re-arm one cycle after the gap, with the new step already stable.
                        r_pwm_ready <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ack       = w_ack;
    assign busy      = w_busy;
    assign grant_id  = r_grant_id;
    assign pwm_duty  = r_pwm_duty;
    assign pwm_ready = r_pwm_ready;
    assign cur_duty  = r_cur_duty;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pwm_duty_scheduler                                           |
// | Brief    : Scoreboard bench for pwm_duty_scheduler (PWM_SCHED_RAMP_EN aware)|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pwm_duty_scheduler;

    localparam int c_r   = 8;
    localparam int c_n   = 4;
    localparam int c_lat = 3;

    logic                 clk;
    logic                 reset;
    logic [c_n-1:0]       req;
    logic [c_n*c_r-1:0]   req_duty;
    logic [c_n-1:0]       ack;
    logic                 busy;
    logic [1:0]           grant_id;
    logic [c_r-1:0]       pwm_duty;
    logic                 pwm_ready;
    logic                 pwm_done;
    logic [c_r-1:0]       cur_duty;

    typedef struct {
        int id;
        int duty;
    } ack_t;

    int   exp_hs[$];
    ack_t exp_ack[$];
    int   n_checks;
    int   n_errors;
    int   ack_seen;
    int   model_cur;
    int   cur_exp;
    logic prev_ready;

`ifdef PWM_SCHED_RAMP_EN
    int up_steps[3]  = '{16, 32, 40};
    int dn_steps[12] = '{184, 168, 152, 136, 120, 104, 88, 72, 56, 40, 24, 10};
`else
    int up_steps[1]  = '{40};
    int dn_steps[1]  = '{10};
`endif

    pwm_duty_scheduler #(
        .R        (c_r),
        .N        (c_n),
        .MAX_STEP (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_duty  (req_duty),
        .ack       (ack),
        .busy      (busy),
        .grant_id  (grant_id),
        .pwm_duty  (pwm_duty),
        .pwm_ready (pwm_ready),
        .pwm_done  (pwm_done),
        .cur_duty  (cur_duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected handshake sequence for one transfer, from the bench's own duty model.
    task automatic push_transfer(input int id, input int tgt);
        int c;
        c = model_cur;
`ifdef PWM_SCHED_RAMP_EN
        while (tgt - c > 16) begin
            c += 16;
            exp_hs.push_back(c);
        end
        while (c - tgt > 16) begin
            c -= 16;
            exp_hs.push_back(c);
        end
`endif
        exp_hs.push_back(tgt);
        exp_ack.push_back('{id, tgt});
        model_cur = tgt;
    endtask

    task automatic set_req(input int id, input int duty);
        req_duty[id*c_r +: c_r] = c_r'(duty);
        req[id] = 1'b1;
    endtask

    // PWM model: acknowledges each handshake c_lat cycles after ready is seen.
    task automatic serve_acks(input int n, input int budget);
        int goal;
        int cnt;
        int cyc;
        goal = ack_seen + n;
        cnt  = 0;
        cyc  = 0;
        while (ack_seen < goal && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pwm_done) begin
                pwm_done = 1'b0;
                cnt = 0;
            end else if (pwm_ready) begin
                cnt++;
                if (cnt == c_lat) pwm_done = 1'b1;
            end
        end
        pwm_done = 1'b0;
        check("serve_ack_count", ack_seen - (goal - n), n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_hs.delete();
        exp_ack.delete();
        model_cur = 0;
    endtask

    always @(negedge clk) begin
        ack_t e;
        if (reset) begin
            prev_ready = 1'b0;
        end else begin
            if (pwm_ready && !prev_ready) begin
                if (exp_hs.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL hs_unexpected: got duty %0d, expected no handshake", pwm_duty);
                end else begin
                    cur_exp = exp_hs.pop_front();
                    check("hs_duty", pwm_duty, cur_exp);
                end
            end else if (pwm_ready) begin
                check("hs_duty_stable", pwm_duty, cur_exp);
            end
            if (ack != '0) begin
                if (exp_ack.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ack_unexpected: got ack %b, expected none", ack);
                end else begin
                    e = exp_ack.pop_front();
                    check("ack_vector", ack, 32'(1) << e.id);
                    check("ack_cur_duty", cur_duty, e.duty);
                    check("ack_grant_id", grant_id, e.id);
                end
                ack_seen++;
            end
            prev_ready = pwm_ready;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        ack_seen  = 0;
        model_cur = 0;
        cur_exp   = 0;
        req       = '0;
        req_duty  = '0;
        pwm_done  = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_pwm_ready", pwm_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_duty", cur_duty, 0);
        check("rst_pwm_duty", pwm_duty, 0);
        check("rst_ack", ack, 0);
        check("rst_grant_id", grant_id, 0);

        // Single request from requester 2, ready one cycle after grant
        @(posedge clk);
        #1;
        push_transfer(2, 128);
        set_req(2, 128);
        @(posedge clk);
        @(negedge clk);
        check("grant_pwm_ready", pwm_ready, 1);
        check("grant_busy", busy, 1);
        check("grant_id_2", grant_id, 2);
        serve_acks(1, 400);
        req[2] = 1'b0;
        @(negedge clk);
        check("single_cur_duty", cur_duty, 128);

        // Reset while a handshake is outstanding
        @(posedge clk);
        #1;
        push_transfer(1, 77);
        set_req(1, 77);
        @(posedge clk);
        @(negedge clk);
        check("midissue_ready", pwm_ready, 1);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_pwm_ready", pwm_ready, 0);
        check("midrst_cur_duty", cur_duty, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ack", ack, 0);
        #4;
        reset = 1'b0;
        exp_hs.delete();
        exp_ack.delete();
        model_cur = 0;

        // Round robin with all four requesting; pointer starts at 0 after reset
        @(posedge clk);
        #1;
        push_transfer(0, 50);
        push_transfer(1, 60);
        push_transfer(2, 70);
        push_transfer(3, 80);
        push_transfer(0, 50);
        set_req(0, 50);
        set_req(1, 60);
        set_req(2, 70);
        set_req(3, 80);
        serve_acks(5, 1200);
        req = '0;
        @(negedge clk);
        check("rr_idle_after", busy, 0);

        // Target equal to current duty still takes one handshake
        @(posedge clk);
        #1;
        push_transfer(3, 50);
        set_req(3, 50);
        serve_acks(1, 400);
        req[3] = 1'b0;

        // Winner changes its duty and drops req mid-transfer; latched value wins
        @(posedge clk);
        #1;
        push_transfer(1, 200);
        set_req(1, 200);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        req_duty[1*c_r +: c_r] = 8'd5;
        req[1] = 1'b0;
        serve_acks(1, 800);
        @(negedge clk);
        check("drop_cur_duty", cur_duty, 200);

        // Stray done while idle
        @(posedge clk);
        #1;
        pwm_done = 1'b1;
        @(posedge clk);
        #1;
        pwm_done = 1'b0;
        @(negedge clk);
        check("stray_cur_duty", cur_duty, 200);
        check("stray_busy", busy, 0);
        check("stray_ready", pwm_ready, 0);

        // Up-ramp 0 -> 40 and down-ramp 200 -> 10 with hand-derived steps
        @(posedge clk);
        #1;
        do_reset();
        foreach (up_steps[i]) exp_hs.push_back(up_steps[i]);
        exp_ack.push_back('{0, 40});
        model_cur = 40;
        set_req(0, 40);
        serve_acks(1, 400);
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        push_transfer(2, 200);
        set_req(2, 200);
        serve_acks(1, 800);
        req[2] = 1'b0;
        @(posedge clk);
        #1;
        foreach (dn_steps[i]) exp_hs.push_back(dn_steps[i]);
        exp_ack.push_back('{3, 10});
        model_cur = 10;
        set_req(3, 10);
        serve_acks(1, 1000);
        req[3] = 1'b0;
        @(negedge clk);
        check("ramp_final_cur_duty", cur_duty, 10);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("leftover_handshakes", exp_hs.size(), 0);
        check("leftover_acks", exp_ack.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
